// File: rtl/credit_tx.sv
// Credit-based stream transmitter: two-entry skid buffer feeding a registered,
// ready-less link that may only send while a remote-FIFO credit is held.
module credit_tx #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CBITS   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             cr_return,
    output logic [CBITS-1:0] credits,
    output logic             idle,
    output logic             err
);

    localparam logic [CBITS-1:0] CR_INIT = CBITS'(CREDITS);
    localparam logic [CBITS:0]   CR_MAX  = (CBITS+1)'(CREDITS);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       level;
    logic [CBITS-1:0] cr_q;
    logic             err_q;
    logic             tx_valid_q;
    logic [WIDTH-1:0] tx_data_q;

    logic             send;
    logic             acc;
    logic [CBITS:0]   cr_sum;

    // A credit returned this cycle only becomes spendable after the edge,
    // so send looks at the registered count alone.
    always_comb begin
        send    = (level != 2'd0) && (cr_q != '0);
        a_ready = (level < 2'd2) || send;
        acc     = a_valid && a_ready;
        cr_sum  = {1'b0, cr_q} - (CBITS+1)'(send) + (CBITS+1)'(cr_return);
    end

    // Storage carries no reset; stale contents are unreachable once level is 0.
    always_ff @(posedge clk) begin
        if (acc) begin
            mem[wr_ptr] <= a_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            level      <= 2'd0;
            cr_q       <= CR_INIT;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            if (acc) begin
                wr_ptr <= ~wr_ptr;
            end
            if (send) begin
                rd_ptr    <= ~rd_ptr;
                tx_data_q <= mem[rd_ptr];
            end
            tx_valid_q <= send;

            case ({acc, send})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase

            if (cr_sum > CR_MAX) begin
                cr_q  <= CR_INIT;
                err_q <= 1'b1;
            end else begin
                cr_q <= cr_sum[CBITS-1:0];
            end
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign credits  = cr_q;
    assign err      = err_q;
    assign idle     = (level == 2'd0) && !tx_valid_q && (cr_q == CR_INIT);

endmodule

// File: tb/tb_credit_tx.sv
// Scoreboard bench for credit_tx: directed credit scenarios plus a randomized
// stream against a credit-returning receiver model.
module tb_credit_tx;

    localparam int CREDITS = 4;

    logic        clk;
    logic        rst_n;
    logic [63:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        cr_return;
    logic [2:0]  credits;
    logic        idle;
    logic        err;

    credit_tx #(.WIDTH(64), .CREDITS(CREDITS), .CBITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .a_data(a_data), .a_valid(a_valid),
        .a_ready(a_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .cr_return(cr_return), .credits(credits), .idle(idle), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state: accepted-but-unsent words, credit count, sticky error.
    logic [63:0] sbq[$];
    int          exp_cr;
    logic        exp_err;
    logic        prev_ret;
    int          beats, rets, acc_cnt;
    int          first_acc_cyc, first_beat_cyc;
    int          rq[$];
    bit          prod_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [63:0] d);
        int   n;
        logic ok;
        a_valid = 1'b1;
        a_data  = d;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = a_ready;
            @(posedge clk);
            #1;
            n++;
        end
        a_valid = 1'b0;
        if (!ok) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_return();
        @(posedge clk); #1;
        cr_return = 1'b1;
        @(posedge clk); #1;
        cr_return = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (idle) break;
            if (int'(credits) < CREDITS) begin
                cr_return = 1'b1;
                @(posedge clk); #1;
                cr_return = 1'b0;
            end
        end
        chk("drain_idle", 64'(idle), 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        a_valid   = 1'b0;
        a_data    = '0;
        cr_return = 1'b0;
        prod_done = 1'b0;
        exp_cr    = CREDITS;
        exp_err   = 1'b0;
        prev_ret  = 1'b0;

        // Monitor: pop-and-compare on every beat, track credits from counts.
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    sbq.delete();
                    exp_cr = CREDITS; exp_err = 1'b0; prev_ret = 1'b0;
                    beats = 0; rets = 0; acc_cnt = 0;
                    first_acc_cyc = 0; first_beat_cyc = 0;
                    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
                    chk("rst_credits", 64'(credits), 64'(CREDITS));
                end else begin
                    exp_cr = exp_cr + int'(prev_ret) - int'(tx_valid);
                    rets   = rets + int'(prev_ret);
                    if (exp_cr > CREDITS) begin
                        exp_cr  = CREDITS;
                        exp_err = 1'b1;
                    end
                    if (tx_valid) begin
                        if (beats == 0) first_beat_cyc = cyc;
                        beats++;
                        if (sbq.size() == 0) chk("unexpected_beat", tx_data, 64'hDEAD);
                        else chk("tx_data", tx_data, sbq.pop_front());
                        chk("outstanding_le_credits", 64'((beats - rets) <= CREDITS), 64'd1);
                    end
                    chk("credits", 64'(credits), 64'(exp_cr));
                    chk("err", 64'(err), 64'(exp_err));
                    chk("idle", 64'(idle), 64'(sbq.size() == 0 && !tx_valid && exp_cr == CREDITS));
                    chk("a_ready", 64'(a_ready),
                        64'(sbq.size() < 2 || (sbq.size() > 0 && exp_cr > 0)));
                    prev_ret = cr_return;
                    if (a_valid && a_ready) begin
                        if (acc_cnt == 0) first_acc_cyc = cyc;
                        acc_cnt++;
                        sbq.push_back(a_data);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(a_ready), 64'd1);
        chk("post_rst_idle", 64'(idle), 64'd1);

        // Six words, no returns: four go out, two are held.
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) push(64'h10 + 64'(i));
        repeat (4) @(negedge clk);
        chk("p1_beats", 64'(beats), 64'd4);
        chk("p1_latency", 64'(first_beat_cyc - first_acc_cyc), 64'd2);
        chk("p1_credits", 64'(credits), 64'd0);
        chk("p1_ready", 64'(a_ready), 64'd0);

        // Single returns release held words one at a time.
        pulse_return();
        @(negedge clk);
        chk("p2_cr1", 64'(credits), 64'd1);
        chk("p2_no_beat_yet", 64'(tx_valid), 64'd0);
        @(negedge clk);
        chk("p2_beat14", 64'(tx_valid), 64'd1);
        chk("p2_data14", tx_data, 64'h14);
        chk("p2_cr0", 64'(credits), 64'd0);
        pulse_return();
        repeat (2) @(negedge clk);
        chk("p2_data15", tx_data, 64'h15);
        chk("p2_ready_back", 64'(a_ready), 64'd1);

        // Return coinciding with a send keeps credits at 1.
        pulse_return();
        push(64'hA0);
        a_valid = 1'b1; a_data = 64'hB0; cr_return = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; cr_return = 1'b0;
        @(negedge clk);
        chk("p3_credits", 64'(credits), 64'd1);
        chk("p3_tx_valid", 64'(tx_valid), 64'd1);
        chk("p3_data", tx_data, 64'hA0);
        chk("p3_err", 64'(err), 64'd0);
        drain();

        // Spurious return while full of credits sets sticky err.
        pulse_return();
        @(negedge clk);
        chk("p4_credits", 64'(credits), 64'(CREDITS));
        chk("p4_err_set", 64'(err), 64'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) push(64'h30 + 64'(i));
        drain();
        chk("p4_err_sticky", 64'(err), 64'd1);

        // Reset while a beat is on the link and words are buffered.
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) push(64'h20 + 64'(i));
        pulse_return();
        @(posedge clk); #1;
        chk("p5_beat_before_rst", 64'(tx_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("p5_tx_valid", 64'(tx_valid), 64'd0);
        chk("p5_credits", 64'(credits), 64'(CREDITS));
        chk("p5_idle", 64'(idle), 64'd1);
        chk("p5_err_clr", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("p5_no_stale", 64'(beats), 64'd0);

        // Random stream against a receiver returning credits after 0-5 cycles.
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    push({$urandom(), $urandom()});
                end
                prod_done = 1'b1;
            end
            begin
                int n;
                bit done;
                n = 0;
                done = 1'b0;
                while (!done && n < 60000) begin
                    @(negedge clk);
                    if (tx_valid) rq.push_back(cyc + int'($urandom_range(0, 5)));
                    if (prod_done && rq.size() == 0 && sbq.size() == 0 && !tx_valid) done = 1'b1;
                    else begin
                        @(posedge clk); #1;
                        if (rq.size() > 0 && rq[0] <= cyc) begin
                            cr_return = 1'b1;
                            void'(rq.pop_front());
                        end else cr_return = 1'b0;
                    end
                    n++;
                end
                if (!done) chk("rand_timeout", 64'd0, 64'd1);
                @(posedge clk); #1;
                cr_return = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("rand_accepted", 64'(acc_cnt), 64'd1000);
        chk("rand_delivered", 64'(beats), 64'd1000);
        chk("rand_err", 64'(err), 64'd0);
        chk("rand_idle", 64'(idle), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
